prog_counter: RTL

//  Fetch-stage program counter. Drives the instruction address into the instruction ROM every cycle.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/jump_target.sv | 23 ++
 rtl/prog_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-stage program counter.
// JUMP_LUT is only consulted when PC_JUMP_LUT_EN is defined.
package cpu_pkg;

    localparam int ADDR_W = 10;

    typedef logic [ADDR_W-1:0] inst_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        HALT
    } pc_state_t;

    // Absolute je/jne destinations, indexed by the decoder's choice field.
    localparam logic [9:0] JUMP_LUT [8] = '{
        10'd0, 10'd16, 10'd64, 10'd128, 10'd256, 10'd300, 10'd512, 10'd1000
    };

endpackage

// File: rtl/jump_target.sv
// Branch target for je/jne. With PC_JUMP_LUT_EN defined the target is an absolute
// table entry; otherwise it is PC plus the sign-extended choice field, modulo 2**A.
module jump_target
    import cpu_pkg::*;
#(
    parameter int A     = 10,
    parameter int OFF_W = 3
) (
    input  logic [A-1:0]     pc,
    input  logic [OFF_W-1:0] sel,
    output logic [A-1:0]     target
);

`ifdef PC_JUMP_LUT_EN
    logic unused_pc;

    assign unused_pc = ^pc;
    assign target    = A'(JUMP_LUT[sel]);
`else
    assign target = pc + {{(A-OFF_W){sel[OFF_W-1]}}, sel};
`endif

endmodule

// File: rtl/prog_counter.sv
// Fetch-stage program counter: IDLE/ARMED/RUN/HALT sequencing, next-PC selection and
// a saturating RUN cycle counter. Branch target mode is selected by PC_JUMP_LUT_EN.
module prog_counter
    import cpu_pkg::*;
#(
    parameter int A     = 10,
    parameter int OFF_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchTaken,
    input  logic [OFF_W-1:0] BranchSel,
    input  logic             Halt,
    output logic [A-1:0]     InstAddress,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pc_state_t        state_reg, state_next;
    logic [A-1:0]     pc_reg, pc_next;
    logic [A-1:0]     target;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    jump_target #(
        .A     (A),
        .OFF_W (OFF_W)
    ) u_jump_target (
        .pc     (pc_reg),
        .sel    (BranchSel),
        .target (target)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                pc_next = '0;
                if (Start) state_next = ARMED;
            end
            ARMED: begin
                // PC stays 0 on the launch edge so the ROM sees address 0 in the first RUN cycle.
                pc_next  = '0;
                cnt_next = '0;
                if (!Start) state_next = RUN;
            end
            RUN: begin
                cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
                if (Start) begin
                    state_next = ARMED;
                    pc_next    = '0;
                    cnt_next   = '0;
                end else if (Halt) begin
                    state_next = HALT;
                end else if (!Stall) begin
                    // A taken branch under stall is deliberately dropped; the decoder re-presents it.
                    if (BranchEn && BranchTaken) pc_next = target;
                    else                         pc_next = pc_reg + A'(1);
                end
            end
            HALT: begin
                if (Start) begin
                    state_next = ARMED;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign InstAddress = pc_reg;
    assign Running     = (state_reg == RUN);
    assign Done        = (state_reg == HALT);
    assign CycleCount  = cnt_reg;

endmodule
